// File: rtl/rfid_pkg.sv
// Shared definitions for the card-to-reader link: symbol and receiver
// state encodings, symbol classifier, frame sizing constants.
package rfid_pkg;

    localparam int QUARTERS_PER_BIT  = 4;
    localparam int DEFAULT_MAX_BYTES = 5;

    typedef enum logic [1:0] {
        SYM_X,
        SYM_Y,
        SYM_Z,
        SYM_BAD
    } sym_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_TAIL,
        ST_DATA,
        ST_PARITY,
        ST_DONE,
        ST_ERROR
    } rx_state_e;

    // q[3] is the first quarter (q0), q[0] the last (q3)
    function automatic sym_e classify(input logic [3:0] q);
        sym_e s;
        case (q)
            4'b1101: s = SYM_X;
            4'b1111: s = SYM_Y;
            4'b0111: s = SYM_Z;
            default: s = SYM_BAD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/picc_sym_sampler.sv
// Quarter-bit sampler: collects q0..q2, classifies with live q3 and
// presents one registered symbol per bit period while run is high.
module picc_sym_sampler
    import rfid_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic run,
    input  logic env_in,
    output logic sym_valid,
    output sym_e sym
);

    localparam int QW = $clog2(QUARTERS_PER_BIT);
    localparam int SW = QUARTERS_PER_BIT - 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTERS_PER_BIT - 1);

    logic [QW-1:0] q_cnt_q, q_cnt_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          valid_q, valid_d;
    sym_e          sym_q, sym_d;

    always_comb begin
        q_cnt_d = q_cnt_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        sym_d   = sym_q;
        if (run) begin
            q_cnt_d = q_cnt_q + QW'(1);
            shift_d = {shift_q[SW-2:0], env_in};
            if (q_cnt_q == Q_LAST) begin
                valid_d = 1'b1;
                sym_d   = classify({shift_q, env_in});
            end
        end else begin
            q_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_cnt_q <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            sym_q   <= SYM_BAD;
        end else begin
            q_cnt_q <= q_cnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            sym_q   <= sym_d;
        end
    end

    assign sym_valid = valid_q;
    assign sym       = sym_q;

endmodule

// File: rtl/pcd_rx_decoder.sv
// Reader-side modified-Miller frame decoder (LSB-first bytes + parity).
// Define PCD_RX_PARITY_CHECK_EN to flag parity mismatches on parity_err.
module pcd_rx_decoder
    import rfid_pkg::*;
#(
    parameter int MAX_BYTES = DEFAULT_MAX_BYTES
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   env_in,
    output logic [8*MAX_BYTES-1:0] data_out,
    output logic [2:0]             num_bytes_out,
    output logic                   rx_busy,
    output logic                   rx_done,
    output logic                   rx_err,
    output logic                   parity_err
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int IW = $clog2(DW);

    rx_state_e state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          prev_q, prev_d;
    logic          bit0_y_q, bit0_y_d;
    logic          perr_q, perr_d;
    logic [2:0]    num_q, num_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [2:0]    hi_cnt_q, hi_cnt_d;

    logic          sym_valid;
    sym_e          sym;
    logic          run;
    logic          sym_bit;
    logic          sym_ok;
    logic          sym_end;
    logic          at_max;
    logic          go_done;
    logic          go_err;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] byte_base;

    assign run = (state_q == ST_DATA) || (state_q == ST_PARITY);

    picc_sym_sampler u_sampler (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .run       (run),
        .env_in    (env_in),
        .sym_valid (sym_valid),
        .sym       (sym)
    );

    assign sym_bit   = (sym == SYM_X);
    assign sym_ok    = (sym == SYM_X)
                     || ((sym == SYM_Y) && prev_q)
                     || ((sym == SYM_Z) && !prev_q);
    assign sym_end   = (sym == SYM_Y) && !prev_q;
    assign at_max    = (byte_cnt_q == 3'(MAX_BYTES));
    assign wr_idx    = IW'({byte_cnt_q, bit_cnt_q});
    assign byte_base = IW'({byte_cnt_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        prev_d     = prev_q;
        bit0_y_d   = bit0_y_q;
        perr_d     = perr_q;
        num_d      = num_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        hi_cnt_d   = hi_cnt_q;
        go_done    = 1'b0;
        go_err     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!env_in) begin
                    state_d    = ST_START_TAIL;
                    data_d     = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    perr_d     = 1'b0;
                    prev_d     = 1'b0;
                    bit0_y_d   = 1'b0;
                end
            end
            ST_START_TAIL: begin
                state_d = env_in ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
                if (sym_valid) begin
                    if (sym_end) begin
                        if (byte_cnt_q != '0 && bit_cnt_q == 3'd0) begin
                            go_done = 1'b1;
                        end else if (byte_cnt_q != '0 && bit_cnt_q == 3'd1
                                     && bit0_y_q) begin
                            // trailing idle after a parity 1 read as a Y bit
                            go_done = 1'b1;
                            if (!at_max) data_d[byte_base] = 1'b0;
                        end else begin
                            go_err = 1'b1;
                        end
                    end else if (!sym_ok) begin
                        go_err = 1'b1;
                    end else if (at_max
                                 && !(bit_cnt_q == 3'd0 && sym == SYM_Y)) begin
                        go_err = 1'b1;
                    end else begin
                        if (!at_max) data_d[wr_idx] = sym_bit;
                        prev_d = sym_bit;
                        if (bit_cnt_q == 3'd0) bit0_y_d = (sym == SYM_Y);
                        if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                        else bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sym_valid) begin
                    if (!sym_ok) begin
                        go_err = 1'b1;
                    end else begin
`ifdef PCD_RX_PARITY_CHECK_EN
                        if (sym_bit != ^data_q[byte_base +: 8]) perr_d = 1'b1;
`endif
                        prev_d     = sym_bit;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (!env_in) begin
                    hi_cnt_d = '0;
                end else if (hi_cnt_q == 3'd7) begin
                    hi_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    hi_cnt_d = hi_cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (go_done) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            num_d   = byte_cnt_q;
        end
        if (go_err) begin
            state_d  = ST_ERROR;
            err_d    = 1'b1;
            num_d    = '0;
            hi_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            prev_q     <= 1'b0;
            bit0_y_q   <= 1'b0;
            perr_q     <= 1'b0;
            num_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hi_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            prev_q     <= prev_d;
            bit0_y_q   <= bit0_y_d;
            perr_q     <= perr_d;
            num_q      <= num_d;
            done_q     <= done_d;
            err_q      <= err_d;
            hi_cnt_q   <= hi_cnt_d;
        end
    end

    assign data_out      = data_q;
    assign num_bytes_out = num_q;
    assign rx_busy       = run || (state_q == ST_START_TAIL);
    assign rx_done       = done_q;
    assign rx_err        = err_q;
`ifdef PCD_RX_PARITY_CHECK_EN
    assign parity_err    = perr_q;
`else
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pcd_rx_decoder.sv
// Self-checking bench for pcd_rx_decoder: vector table, directed
// corner sequences and random frames against a frame-level model.
module tb_pcd_rx_decoder;

    localparam int MB = 5;
`ifdef PCD_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          env_in = 1'b1;
    logic [8*MB-1:0] data_out;
    logic [2:0]    num_bytes_out;
    logic          rx_busy;
    logic          rx_done;
    logic          rx_err;
    logic          parity_err;

    pcd_rx_decoder #(.MAX_BYTES(MB)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .env_in        (env_in),
        .data_out      (data_out),
        .num_bytes_out (num_bytes_out),
        .rx_busy       (rx_busy),
        .rx_done       (rx_done),
        .rx_err        (rx_err),
        .parity_err    (parity_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    bit   sq[$];
    bit   busy_tr[$];
    int   rst_idx = -1;
    int   n_done, n_err, idx_done, idx_err;
    int   cap_num, err_num;
    bit   cap_perr;
    logic [63:0] cap_data;
    logic [63:0] rst_snap;

    typedef struct {
        int          n;
        logic [63:0] d;
        int          flip;
        logic [63:0] xdata;
        int          xnum;
        bit          xperr;
    } vec_t;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_idle(int n);
        repeat (n) sq.push_back(1'b1);
    endtask

    task automatic push_sym(logic [3:0] s);
        for (int i = 3; i >= 0; i--) sq.push_back(s[i]);
    endtask

    // Transmitter: start X, then per bit X for 1, Y/Z for 0 by prev bit.
    // A bad symbol (0000) at index 'bad' ends the emitted frame.
    task automatic push_frame(input int lead, input int n,
                              input logic [63:0] d, input int flip,
                              input int bad, output int zi);
        bit prev;
        bit b;
        int k;
        prev = 1'b0;
        k = 0;
        push_idle(lead);
        zi = sq.size();
        sq.push_back(1'b0);
        sq.push_back(1'b1);
        for (int by = 0; by < n; by++) begin
            for (int j = 0; j < 9; j++) begin
                if (j < 8) b = d[8*by+j];
                else b = (^d[8*by +: 8]) ^ flip[by];
                if (k == bad) begin
                    push_sym(4'b0000);
                    return;
                end
                if (b) push_sym(4'b1101);
                else if (prev) push_sym(4'b1111);
                else push_sym(4'b0111);
                prev = b;
                k++;
            end
        end
    endtask

    // Symbol k of a frame whose start pause is at zi is acted on
    // one sample after its q3, i.e. at sample zi + 6 + 4k.
    function automatic int sym_done(int zi, int k);
        return zi + 6 + 4 * k;
    endfunction

    // A parity 1 leaves the line looking like one extra 0 bit
    // before the end marker.
    function automatic int good_end(int zi, int n, logic [63:0] d,
                                    int flip);
        bit p;
        p = (^d[8*(n-1) +: 8]) ^ flip[n-1];
        return sym_done(zi, 9 * n + int'(p));
    endfunction

    task automatic run_seq();
        n_done = 0;
        n_err = 0;
        idx_done = -1;
        idx_err = -1;
        err_num = -1;
        cap_num = -1;
        rst_snap = '1;
        busy_tr.delete();
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk_in);
            env_in = sq[i];
            rst_in = (i == rst_idx);
            @(posedge clk_in);
            #1;
            busy_tr.push_back(rx_busy);
            if (rx_done) begin
                n_done++;
                if (idx_done < 0) idx_done = i;
                cap_data = 64'(data_out);
                cap_num = int'(num_bytes_out);
                cap_perr = parity_err;
            end
            if (rx_err) begin
                n_err++;
                if (idx_err < 0) idx_err = i;
                err_num = int'(num_bytes_out);
            end
            if (i == rst_idx)
                rst_snap = 64'({data_out, num_bytes_out, rx_busy,
                                rx_done, rx_err, parity_err});
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        env_in = 1'b1;
        sq.delete();
        rst_idx = -1;
    endtask

    vec_t tbl[5];

    initial begin
        int zi, zi2, e, ex;
        logic [63:0] d, mask;
        int n, flip, bad, lead;

        tbl[0] = '{1, 64'hA5, 0, 64'hA5, 1, 1'b0};
        tbl[1] = '{2, 64'h8001, 0, 64'h8001, 2, 1'b0};
        tbl[2] = '{1, 64'hA5, 1, 64'hA5, 1, PCHK};
        tbl[3] = '{5, 64'h01_44_33_22_11, 0, 64'h01_44_33_22_11, 5, 1'b0};
        tbl[4] = '{3, 64'h5A_FF_00, 2, 64'h5A_FF_00, 3, PCHK};

        // reset state
        rst_in = 1'b1;
        env_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_outputs",
            64'({data_out, num_bytes_out, rx_busy, rx_done, rx_err,
                 parity_err}), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        foreach (tbl[v]) begin
            push_frame(2, tbl[v].n, tbl[v].d, tbl[v].flip, -1, zi);
            push_idle(14);
            ex = good_end(zi, tbl[v].n, tbl[v].d, tbl[v].flip);
            run_seq();
            chk($sformatf("v%0d_done_cnt", v), n_done, 1);
            chk($sformatf("v%0d_err_cnt", v), n_err, 0);
            chk($sformatf("v%0d_done_idx", v), idx_done, ex);
            chk($sformatf("v%0d_data", v), cap_data, tbl[v].xdata);
            chk($sformatf("v%0d_num", v), cap_num, tbl[v].xnum);
            chk($sformatf("v%0d_perr", v), cap_perr, tbl[v].xperr);
            chk($sformatf("v%0d_busy_pre", v), busy_tr[zi-1], 0);
            chk($sformatf("v%0d_busy_start", v), busy_tr[zi], 1);
            chk($sformatf("v%0d_busy_last", v), busy_tr[ex-1], 1);
            chk($sformatf("v%0d_busy_end", v), busy_tr[ex], 0);
            chk($sformatf("v%0d_data_hold", v), 64'(data_out),
                tbl[v].xdata);
        end

        // start glitch: two zero samples return to idle silently
        push_idle(3);
        sq.push_back(1'b0);
        sq.push_back(1'b0);
        push_idle(12);
        run_seq();
        chk("glitch_busy_on", busy_tr[3], 1);
        chk("glitch_busy_off", busy_tr[4], 0);
        chk("glitch_err", n_err, 0);
        chk("glitch_done", n_done, 0);

        // bad symbol at bit 3, then error recovery needs 8 highs
        push_frame(2, 1, 64'hA5, 0, 3, zi);
        e = sq.size();
        push_idle(8);
        sq.push_back(1'b0);
        push_idle(8);
        push_frame(0, 1, 64'h3C, 0, -1, zi2);
        push_idle(14);
        run_seq();
        chk("bad_err_cnt", n_err, 1);
        chk("bad_err_idx", idx_err, sym_done(zi, 3));
        chk("bad_err_idx_e", idx_err, e);
        chk("bad_num_zero", err_num, 0);
        chk("bad_busy_err", busy_tr[e], 0);
        chk("bad_still_err", busy_tr[e+8], 0);
        chk("bad_restart", busy_tr[zi2], 1);
        chk("bad_next_done", n_done, 1);
        chk("bad_next_data", cap_data, 64'h3C);

        // overflow: six bytes, error on byte 6 bit 0
        push_frame(2, 6, 64'h66_55_44_33_22_11, 0, -1, zi);
        push_idle(12);
        push_frame(2, 1, 64'h3C, 0, -1, zi2);
        push_idle(14);
        run_seq();
        chk("ovf_err_cnt", n_err, 1);
        chk("ovf_err_idx", idx_err, sym_done(zi, 45));
        chk("ovf_num_zero", err_num, 0);
        chk("ovf_next_done", n_done, 1);
        chk("ovf_next_data", cap_data, 64'h3C);
        chk("ovf_next_num", cap_num, 1);

        // reset mid-frame at byte 2 bit 4
        push_frame(2, 3, 64'h33_22_11, 0, -1, zi);
        rst_idx = zi + 2 + 4 * 13 + 1;
        while (sq.size() > rst_idx + 1) void'(sq.pop_back());
        push_idle(20);
        push_frame(2, 1, 64'h3C, 0, -1, zi2);
        push_idle(14);
        run_seq();
        chk("rst_outputs", rst_snap, 64'd0);
        chk("rst_no_err", n_err, 0);
        chk("rst_next_done", n_done, 1);
        chk("rst_next_idx", idx_done, good_end(zi2, 1, 64'h3C, 0));
        chk("rst_next_data", cap_data, 64'h3C);
        chk("rst_next_num", cap_num, 1);

        // random frames against the frame-level model
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, MB);
            d = {$urandom, $urandom};
            mask = (64'd1 << (8 * n)) - 64'd1;
            d = d & mask;
            flip = ($urandom_range(0, 3) == 0)
                 ? int'($urandom_range(1, 31)) & ((1 << n) - 1) : 0;
            bad = ($urandom_range(0, 3) == 0)
                ? int'($urandom_range(0, 9 * n - 1)) : -1;
            lead = $urandom_range(2, 5);
            push_frame(lead, n, d, flip, bad, zi);
            push_idle(14);
            run_seq();
            if (bad >= 0) begin
                chk($sformatf("r%0d_err_cnt", r), n_err, 1);
                chk($sformatf("r%0d_err_idx", r), idx_err,
                    sym_done(zi, bad));
                chk($sformatf("r%0d_done_cnt", r), n_done, 0);
                chk($sformatf("r%0d_err_num", r), err_num, 0);
            end else begin
                chk($sformatf("r%0d_done_cnt", r), n_done, 1);
                chk($sformatf("r%0d_err_cnt", r), n_err, 0);
                chk($sformatf("r%0d_done_idx", r), idx_done,
                    good_end(zi, n, d, flip));
                chk($sformatf("r%0d_data", r), cap_data, d);
                chk($sformatf("r%0d_num", r), cap_num, n);
                chk($sformatf("r%0d_perr", r), cap_perr,
                    PCHK && (flip != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
